// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired R-type control unit: state encoding,
// datapath bus/enable indices, opcodes, ALU codes and IR field positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    HALT
  } state_t;

  // enable and busSelect share one index space
  localparam logic [4:0] SEL_ZLOW = 5'd19;
  localparam logic [4:0] SEL_PC   = 5'd20;
  localparam logic [4:0] SEL_MDR  = 5'd21;
  localparam logic [4:0] SEL_IR   = 5'd23;
  localparam logic [4:0] SEL_Z    = 5'd24;
  localparam logic [4:0] SEL_MAR  = 5'd25;
  localparam logic [4:0] SEL_Y    = 5'd27;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_HALT = 5'd31;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_ROR  = 4'd9;
  localparam logic [3:0] ALU_ROL  = 4'd10;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational IR decode: ALU operation code, legality, halt detect and
// register fields.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  alu_op,
  output logic        legal,
  output logic        is_halt,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc
);

  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[OPC_HI:OPC_LO];
  assign ra        = ir[RA_HI:RA_LO];
  assign rb        = ir[RB_HI:RB_LO];
  assign rc        = ir[RC_HI:RC_LO];
  assign is_halt   = (opcode == OP_HALT);
  assign unused_ir = ^ir[RC_LO-1:0];

  // halt is deliberately not "legal": it has its own path out of T3
  always_comb begin
    alu_op = ALU_NONE;
    legal  = 1'b1;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_SHR:  alu_op = ALU_SHR;
      OP_SHRA: alu_op = ALU_SHRA;
      OP_SHL:  alu_op = ALU_SHL;
      OP_ROR:  alu_op = ALU_ROR;
      OP_ROL:  alu_op = ALU_ROL;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_rtype_control_unit.sv
// Hardwired control unit sequencing fetch (T0-T2) and register-register ALU
// execution (T3-T5) for the phase-1 datapath.
module alu_rtype_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int ICNT_W      = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic [31:0]       ir,
  input  logic              mem_ready,
  output logic [31:0]       enable,
  output logic [31:0]       busSelect,
  output logic              MD_Read,
  output logic              IncPC,
  output logic [3:0]        Control_Signals,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic              bus_err,
  output logic [ICNT_W-1:0] instr_count
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        alu_op;
  logic              legal;
  logic              is_halt;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rc;

  opcode_decoder u_decoder (
    .ir      (ir),
    .alu_op  (alu_op),
    .legal   (legal),
    .is_halt (is_halt),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc)
  );

  // T1 may last at most MEM_TIMEOUT cycles; mem_ready in the last one still wins
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
      bus_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) state <= T0;
        T0: begin
          wait_cnt <= '0;
          state    <= T1;
        end
        T1: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (mem_ready) begin
            state <= T2;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= HALT;
            bus_err <= 1'b1;
          end
        end
        T2: state <= T3;
        T3: begin
          if (legal)        state <= T4;
          else if (is_halt) state <= HALT;
          else              state <= run ? T0 : IDLE;
        end
        T4: state <= T5;
        T5: begin
          instr_count <= instr_count + ICNT_W'(1);
          state       <= run ? T0 : IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    enable          = '0;
    busSelect       = '0;
    MD_Read         = 1'b0;
    IncPC           = 1'b0;
    Control_Signals = ALU_NONE;
    busy            = 1'b0;
    halted          = 1'b0;
    illegal         = 1'b0;
    case (state)
      T0: begin
        busSelect = onehot32(SEL_PC);
        enable    = onehot32(SEL_MAR) | onehot32(SEL_PC);
        IncPC     = 1'b1;
        busy      = 1'b1;
      end
      T1: begin
        enable  = onehot32(SEL_MDR);
        MD_Read = 1'b1;
        busy    = 1'b1;
      end
      T2: begin
        busSelect = onehot32(SEL_MDR);
        enable    = onehot32(SEL_IR);
        busy      = 1'b1;
      end
      T3: begin
        busy = 1'b1;
        if (legal) begin
          busSelect = onehot32({1'b0, rb});
          enable    = onehot32(SEL_Y);
        end else if (!is_halt) begin
          illegal = 1'b1;
        end
      end
      T4: begin
        busSelect       = onehot32({1'b0, rc});
        enable          = onehot32(SEL_Z);
        Control_Signals = alu_op;
        busy            = 1'b1;
      end
      T5: begin
        busSelect = onehot32(SEL_ZLOW);
        enable    = onehot32({1'b0, ra});
        busy      = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule
